// File: rtl/counter_sweep_pkg.sv
// Shared encodings for the counter sweep sequencer: FSM states and run modes.
package counter_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_CONT   = 1'b1;

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// CSR-side control and status bundle of the sweep sequencer.
interface counter_sweep_ctrl_if #(
    parameter int N     = 8,
    parameter int PSC_W = 8
);
    // start is a level request consumed only in IDLE (no ready); busy is the
    // back-pressure indication, and start while busy is silently dropped.
    logic             start;
    logic             stop;
    logic             mode;
    logic [N-1:0]     top;
    logic [PSC_W-1:0] prescale;
    logic [N-1:0]     count;
    logic             busy;
    logic             dir;
    logic             apex;
    logic             wrap;
    logic             done;

    modport master (
        output start, stop, mode, top, prescale,
        input  count, busy, dir, apex, wrap, done
    );

    modport slave (
        input  start, stop, mode, top, prescale,
        output count, busy, dir, apex, wrap, done
    );
endinterface

// File: rtl/counter_sweep_ctrl_counter.sv
// N-bit up/down counter with enable and asynchronous active-low reset.
module counter_sweep_ctrl_counter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         up_down,
    output logic [N-1:0] count
);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (enable) begin
            count <= up_down ? count + ONE : count - ONE;
        end
    end
endmodule

// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer (0 -> top -> 0) driving an up/down counter once per
// prescaled tick, with single-shot or continuous operation and status pulses.
module counter_sweep_ctrl
    import counter_sweep_pkg::*;
#(
    parameter int N     = 8,
    parameter int PSC_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    counter_sweep_ctrl_if.slave  bus,
    output logic [1:0]           dbg_state
);
    localparam logic [N-1:0]     CNT_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [PSC_W-1:0] PSC_ONE = {{(PSC_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [N-1:0]     top_q, top_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [PSC_W-1:0] pcnt_q, pcnt_d;
    logic             mode_q, mode_d;
    logic             stop_pend_q, stop_pend_d;
    logic             apex_q, apex_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             running;
    logic             tick;
    logic [N-1:0]     count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            top_q       <= '0;
            psc_q       <= '0;
            pcnt_q      <= '0;
            mode_q      <= MODE_SINGLE;
            stop_pend_q <= 1'b0;
            apex_q      <= 1'b0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            top_q       <= top_d;
            psc_q       <= psc_d;
            pcnt_q      <= pcnt_d;
            mode_q      <= mode_d;
            stop_pend_q <= stop_pend_d;
            apex_q      <= apex_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        top_d       = top_q;
        psc_d       = psc_q;
        pcnt_d      = pcnt_q;
        mode_d      = mode_q;
        stop_pend_d = stop_pend_q;
        apex_d      = 1'b0;
        wrap_d      = 1'b0;
        done_d      = 1'b0;
        running     = (state_q != ST_IDLE);
        tick        = running && (pcnt_q == '0);

        if (running) begin
            pcnt_d = tick ? psc_q : pcnt_q - PSC_ONE;
            // A stop arriving in the very cycle of a return to 0 still ends the run there.
            if (bus.stop) stop_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    top_d  = bus.top;
                    psc_d  = bus.prescale;
                    mode_d = bus.mode;
                    pcnt_d = bus.prescale;
                    if (bus.top == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = ST_UP;
                        stop_pend_d = bus.stop;
                    end
                end
            end
            ST_UP: begin
                if (tick && count == top_q - CNT_ONE) begin
                    state_d = ST_DOWN;
                    apex_d  = 1'b1;
                end
            end
            ST_DOWN: begin
                if (tick && count == CNT_ONE) begin
                    if (mode_q == MODE_SINGLE || stop_pend_d) begin
                        state_d     = ST_IDLE;
                        done_d      = 1'b1;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d = ST_UP;
                        wrap_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    counter_sweep_ctrl_counter #(.N(N)) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (tick),
        .up_down (state_q == ST_UP),
        .count   (count)
    );

    assign bus.count = count;
    assign bus.busy  = running;
    assign bus.dir   = (state_q == ST_UP);
    assign bus.apex  = apex_q;
    assign bus.wrap  = wrap_q;
    assign bus.done  = done_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl: step-index reference model checked every
// cycle, plus literal expectations taken from hand-worked sweeps.
module tb_counter_sweep_ctrl;
    import counter_sweep_pkg::*;

    localparam int N     = 8;
    localparam int PSC_W = 8;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    counter_sweep_ctrl_if #(.N(N), .PSC_W(PSC_W)) bus ();
    logic [1:0] dbg_state;

    counter_sweep_ctrl #(.N(N), .PSC_W(PSC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // reference model: position m_s along the sweep, 0..2*top
    int   m_s = 0, m_top = 0, m_psc = 0, m_wait = 0;
    logic m_run = 0, m_mode = 0, m_stop = 0;
    logic m_apex = 0, m_wrap = 0, m_done = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s = 0; m_top = 0; m_run = 0; m_stop = 0;
            m_apex = 0; m_wrap = 0; m_done = 0;
        end else begin
            m_apex = 0; m_wrap = 0; m_done = 0;
            if (!m_run) begin
                if (bus.start) begin
                    if (bus.top == 0) begin
                        m_done = 1;
                    end else begin
                        m_run = 1; m_top = int'(bus.top); m_psc = int'(bus.prescale);
                        m_mode = bus.mode; m_stop = bus.stop; m_wait = int'(bus.prescale); m_s = 0;
                    end
                end
            end else begin
                if (bus.stop) m_stop = 1;
                if (m_wait == 0) begin
                    m_wait = m_psc;
                    m_s++;
                    if (m_s == m_top) m_apex = 1;
                    if (m_s == 2 * m_top) begin
                        if (!m_mode || m_stop) begin
                            m_run = 0; m_done = 1; m_stop = 0;
                        end else begin
                            m_s = 0; m_wrap = 1;
                        end
                    end
                end else begin
                    m_wait--;
                end
            end
        end
    end

    // scoreboard: one packed status word per cycle
    logic [14:0] dut_vec;
    assign dut_vec = {bus.count, bus.busy, bus.dir, bus.apex, bus.wrap, bus.done, dbg_state};

    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            logic [7:0]  e_cnt;
            logic        e_dir;
            logic [1:0]  e_st;
            e_cnt = (m_s <= m_top) ? 8'(m_s) : 8'(2 * m_top - m_s);
            e_dir = m_run && (m_s < m_top);
            e_st  = !m_run ? ST_IDLE : (e_dir ? ST_UP : ST_DOWN);
            check("cycle", 32'(dut_vec), 32'({e_cnt, m_run, e_dir, m_apex, m_wrap, m_done, e_st}));
        end
    end

    // driver tasks
    task automatic edge_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(input int t, input int p, input logic md, input logic stp);
        bus.top = 8'(t); bus.prescale = 8'(p); bus.mode = md;
        bus.start = 1'b1; bus.stop = stp;
        edge_n(1);
        bus.start = 1'b0; bus.stop = 1'b0;
    endtask

    int t1_cnt[6]  = '{1, 2, 3, 2, 1, 0};
    int t2_cnt[12] = '{0, 0, 1, 1, 1, 2, 2, 2, 1, 1, 1, 0};
    int t3_cnt[8]  = '{1, 2, 1, 0, 1, 2, 1, 0};

    initial begin
        bus.start = 0; bus.stop = 0; bus.mode = 0; bus.top = 0; bus.prescale = 0;
        #3;
        check("reset_status", 32'(dut_vec), 32'(0));
        edge_n(2);
        rst_n = 1'b1;

        // single sweep, prescale 0, started in first cycle after release
        launch(3, 0, MODE_SINGLE, 0);
        check("t1_busy_e0", 32'(bus.busy), 32'(1));
        for (int i = 1; i <= 6; i++) begin
            edge_n(1);
            check("t1_count", 32'(bus.count), 32'(t1_cnt[i-1]));
            check("t1_apex", 32'(bus.apex), 32'(i == 3));
            check("t1_done", 32'(bus.done), 32'(i == 6));
        end
        check("t1_busy_end", 32'(bus.busy), 32'(0));
        edge_n(2);

        // prescaled single sweep
        launch(2, 2, MODE_SINGLE, 0);
        for (int i = 1; i <= 12; i++) begin
            edge_n(1);
            check("t2_count", 32'(bus.count), 32'(t2_cnt[i-1]));
            check("t2_apex", 32'(bus.apex), 32'(i == 6));
            check("t2_done", 32'(bus.done), 32'(i == 12));
        end
        edge_n(2);

        // continuous with graceful stop pulsed while count = 2
        launch(2, 0, MODE_CONT, 0);
        for (int i = 1; i <= 8; i++) begin
            edge_n(1);
            if (i == 7) bus.stop = 1'b0;
            check("t3_count", 32'(bus.count), 32'(t3_cnt[i-1]));
            check("t3_wrap", 32'(bus.wrap), 32'(i == 4));
            check("t3_done", 32'(bus.done), 32'(i == 8));
            if (i == 6) bus.stop = 1'b1;
        end
        edge_n(1);
        check("t3_idle", 32'({bus.count, bus.busy}), 32'(0));
        edge_n(1);

        // top = 0: immediate done, never busy
        launch(0, 0, MODE_SINGLE, 0);
        check("t4_done", 32'({bus.done, bus.busy, bus.count}), 32'({1'b1, 1'b0, 8'd0}));
        edge_n(1);
        check("t4_after", 32'({bus.done, bus.busy, bus.count}), 32'(0));

        // start and stop together in continuous mode: one sweep only
        launch(1, 0, MODE_CONT, 1);
        edge_n(1);
        check("t5_apex", 32'({bus.count, bus.apex}), 32'({8'd1, 1'b1}));
        edge_n(1);
        check("t5_done", 32'({bus.count, bus.done, bus.wrap}), 32'({8'd0, 1'b1, 1'b0}));
        edge_n(2);

        // start and top changes mid-run are ignored
        launch(2, 0, MODE_SINGLE, 0);
        bus.top = 8'd5; bus.start = 1'b1; bus.mode = MODE_CONT;
        edge_n(3);
        check("t6_mid", 32'(bus.count), 32'(1));
        bus.start = 1'b0;
        edge_n(1);
        check("t6_done", 32'({bus.count, bus.done}), 32'({8'd0, 1'b1}));
        edge_n(2);

        // asynchronous reset while descending through 2
        launch(3, 0, MODE_SINGLE, 0);
        edge_n(4);
        check("t7_pre", 32'({bus.count, bus.dir}), 32'({8'd2, 1'b0}));
        rst_n = 1'b0;
        #1;
        check("t7_reset", 32'(dut_vec), 32'(0));
        edge_n(2);
        rst_n = 1'b1;
        launch(1, 0, MODE_SINGLE, 0);
        edge_n(1);
        check("t7_apex", 32'({bus.count, bus.apex}), 32'({8'd1, 1'b1}));
        edge_n(1);
        check("t7_done", 32'({bus.count, bus.done}), 32'({8'd0, 1'b1}));
        edge_n(2);

        // maximum apex
        launch(255, 0, MODE_SINGLE, 0);
        edge_n(255);
        check("t8_apex", 32'({bus.count, bus.apex}), 32'({8'd255, 1'b1}));
        edge_n(255);
        check("t8_done", 32'({bus.count, bus.done, bus.busy}), 32'({8'd0, 1'b1, 1'b0}));
        edge_n(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
